// File: rtl/apb_master.sv
// APB requester: takes one command at a time, runs the APB SETUP/ACCESS
// sequence, and returns the result through a valid/ready response port.
// An ACCESS phase that is still waiting after TIMEOUT_CYCLES cycles is
// abandoned and reported with both the error and timeout flags set.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,

  // Command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,

  // Response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,

  // APB requester side
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The limit is compared against an 8-bit cycle counter.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [7:0] access_count;

  logic       cmd_accept;
  logic       access_done;
  logic       access_expired;

  // Event decode shared by the state register and the datapath registers.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    cmd_accept     = 1'b0;
    access_done    = 1'b0;
    access_expired = 1'b0;
    if (state == IDLE) begin
      cmd_accept = cmd_valid;
    end
    if (state == ACCESS) begin
      // A completer that finishes on the timeout cycle wins over the timeout.
      access_done    = PREADY;
      access_expired = !PREADY && ((access_count + 8'd1) == TIMEOUT_LIMIT);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cmd_accept) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (access_done || access_expired) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight without a response.
  always_ff @(posedge PCLK) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Control outputs are pure decodes of the state.
  always_comb begin
    cmd_ready = (state == IDLE);
    PSEL      = (state == SETUP) || (state == ACCESS);
    PENABLE   = (state == ACCESS);
    rsp_valid = (state == RESP);
  end

  // Address, write data and direction are captured only when a command is
  // taken, so they stay stable through SETUP/ACCESS and hold afterwards.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (cmd_accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // ACCESS cycle counter: cleared as SETUP is entered, advanced each ACCESS cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      access_count <= '0;
    end else if (cmd_accept) begin
      access_count <= '0;
    end else if (state == ACCESS) begin
      access_count <= access_count + 8'd1;
    end
  end

  // Response registers load only at the edge that leaves ACCESS and then
  // hold until the next transfer completes.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (access_done) begin
      rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
      rsp_err     <= PSLVERR;
      rsp_timeout <= 1'b0;
    end else if (access_expired) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed transfers with literal
// expectations, plus a transaction-timeline model compared every cycle.
module tb_apb_master;

  localparam int TIMEOUT = 16;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Timeline model: a transfer is described by the cycle index of its
  // address phase (m_t0). Every later cycle up to completion is a data-phase
  // cycle; data-phase cycle k (1-based) is cycle m_t0+k.
  // ---------------------------------------------------------------------
  int          m_cyc     = 0;
  int          m_t0      = 0;
  bit          m_on      = 0;
  bit          m_active  = 0;
  bit          m_pending = 0;
  logic        m_write   = 0;
  logic [31:0] m_addr    = 0;
  logic [31:0] m_wdata   = 0;
  logic [31:0] m_rdata   = 0;
  logic        m_err     = 0;
  logic        m_tmo     = 0;

  always @(posedge PCLK) begin
    m_cyc <= m_cyc + 1;
    if (PRESET) begin
      m_on      <= 1;
      m_active  <= 0;
      m_pending <= 0;
      m_write   <= 0;
      m_addr    <= 0;
      m_wdata   <= 0;
      m_rdata   <= 0;
      m_err     <= 0;
      m_tmo     <= 0;
    end else if (m_on) begin
      if (!m_active && !m_pending) begin
        if (cmd_valid) begin
          m_active <= 1;
          m_t0     <= m_cyc + 1;
          m_write  <= cmd_write;
          m_addr   <= cmd_addr;
          m_wdata  <= cmd_wdata;
        end
      end else if (m_active) begin
        if (m_cyc > m_t0) begin
          if (PREADY) begin
            m_active  <= 0;
            m_pending <= 1;
            m_rdata   <= m_write ? 32'h0 : PRDATA;
            m_err     <= PSLVERR;
            m_tmo     <= 0;
          end else if (m_cyc - m_t0 == TIMEOUT) begin
            m_active  <= 0;
            m_pending <= 1;
            m_rdata   <= 32'h0;
            m_err     <= 1;
            m_tmo     <= 1;
          end
        end
      end else if (rsp_ready) begin
        m_pending <= 0;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge PCLK) begin
    if (m_on) begin
      check("m_cmd_ready",   cmd_ready,   !m_active && !m_pending);
      check("m_psel",        PSEL,        m_active);
      check("m_penable",     PENABLE,     m_active && (m_cyc > m_t0));
      check("m_rsp_valid",   rsp_valid,   m_pending);
      check("m_pwrite",      PWRITE,      m_write);
      check("m_paddr",       PADDR,       m_addr);
      check("m_pwdata",      PWDATA,      m_wdata);
      check("m_rsp_rdata",   rsp_rdata,   m_rdata);
      check("m_rsp_err",     rsp_err,     m_err);
      check("m_rsp_timeout", rsp_timeout, m_tmo);
    end
  end

  // ---------------------------------------------------------------------
  // One transfer. Called just after a negedge with the DUT idle (cycle N).
  // waits: number of PREADY=0 data-phase cycles (0 = PREADY tied high,
  // -1 = never ready). hold: cycles rsp_ready stays low while rsp_valid.
  // ---------------------------------------------------------------------
  task automatic do_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] rdata, input logic slverr, input int hold,
                        input bit keep_valid, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_tmo,
                        output int lat, output int n_psel, output int n_pen,
                        output bit bus_ok);
    bit found;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    rsp_ready = 1'b0;
    PREADY    = (waits == 0);
    PRDATA    = (waits == 0) ? rdata : 32'hDEAD_BEEF;
    PSLVERR   = (waits == 0) ? slverr : 1'b1;
    lat    = 0;
    n_psel = 0;
    n_pen  = 0;
    bus_ok = 1;
    found  = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge PCLK);
      if (i == 1) begin
        if (!keep_valid) cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
      end
      if (PSEL) begin
        n_psel++;
        if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr) bus_ok = 0;
      end
      if (PENABLE) n_pen++;
      if (rsp_valid) begin
        lat   = i;
        found = 1;
        break;
      end
      if (waits != 0) begin
        PREADY  = PENABLE && (waits > 0) && (n_pen == waits + 1);
        PRDATA  = PREADY ? rdata : 32'hDEAD_BEEF;
        PSLVERR = PREADY ? slverr : 1'b1;
      end
    end
    check({tag, "_rsp_seen"}, found, 1'b1);
    PREADY  = 1'b0;
    PRDATA  = 32'hDEAD_BEEF;
    PSLVERR = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge PCLK);
      check({tag, "_rsp_valid"},   rsp_valid,   1'b1);
      check({tag, "_rsp_rdata"},   rsp_rdata,   exp_rdata);
      check({tag, "_rsp_err"},     rsp_err,     exp_err);
      check({tag, "_rsp_timeout"}, rsp_timeout, exp_tmo);
      if (h < hold) begin
        check({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_hold_psel"},      PSEL,      1'b0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check({tag, "_after_rsp_valid"},     rsp_valid, 1'b0);
    check({tag, "_after_rsp_psel"},      PSEL,      1'b0);
    check({tag, "_after_rsp_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int lat, n_psel, n_pen;
  bit bus_ok;

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state
    @(negedge PCLK);
    check("rst_psel",      PSEL,      1'b0);
    check("rst_penable",   PENABLE,   1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_paddr",     PADDR,     32'h0);
    check("rst_pwdata",    PWDATA,    32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rel_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write
    do_txn("wr0", 1'b1, 32'h08, 32'hAAAA_FFFF, 0, 32'h0BAD_F00D, 1'b0, 0, 0,
           32'h0, 1'b0, 1'b0, lat, n_psel, n_pen, bus_ok);
    check("wr0_latency", lat,    3);
    check("wr0_psel_n",  n_psel, 2);
    check("wr0_pen_n",   n_pen,  1);
    check("wr0_bus",     bus_ok, 1'b1);

    // Read with three wait states
    do_txn("rd3", 1'b0, 32'h00, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 0, 0,
           32'h1234_5678, 1'b0, 1'b0, lat, n_psel, n_pen, bus_ok);
    check("rd3_latency", lat,    6);
    check("rd3_psel_n",  n_psel, 5);
    check("rd3_pen_n",   n_pen,  4);
    check("rd3_bus",     bus_ok, 1'b1);

    // Read that never completes
    do_txn("tmo", 1'b0, 32'h0000_0010, 32'h0, -1, 32'h5A5A_5A5A, 1'b0, 0, 0,
           32'h0, 1'b1, 1'b1, lat, n_psel, n_pen, bus_ok);
    check("tmo_pen_n",   n_pen,  16);
    check("tmo_latency", lat,    18);
    check("tmo_bus",     bus_ok, 1'b1);

    // Write answered with a completer error
    do_txn("slv", 1'b1, 32'd200, 32'h5555_0000, 0, 32'hFFFF_FFFF, 1'b1, 0, 0,
           32'h0, 1'b1, 1'b0, lat, n_psel, n_pen, bus_ok);
    check("slv_latency", lat, 3);

    // Response back-pressure with a command waiting
    do_txn("bp", 1'b0, 32'h0000_0040, 32'h0, 0, 32'hCAFE_0001, 1'b0, 5, 1,
           32'hCAFE_0001, 1'b0, 1'b0, lat, n_psel, n_pen, bus_ok);
    check("bp_latency", lat, 3);
    // The waiting command is taken now; PSEL must rise in the very next cycle.
    do_txn("bp2", 1'b1, 32'h0000_0044, 32'h0102_0304, 0, 32'h0, 1'b0, 0, 0,
           32'h0, 1'b0, 1'b0, lat, n_psel, n_pen, bus_ok);
    check("bp2_latency", lat,    3);
    check("bp2_psel_n",  n_psel, 2);

    // Reset during ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0030;
    cmd_wdata = 32'h0;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("ar_in_access", PENABLE, 1'b1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("ar_psel",      PSEL,      1'b0);
    check("ar_penable",   PENABLE,   1'b0);
    check("ar_rsp_valid", rsp_valid, 1'b0);
    check("ar_paddr",     PADDR,     32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("ar_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("ar_no_rsp", rsp_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
